// File: rtl/edge_cache.sv
// Single-row read-only cache for the adjacency matrix in shared block RAM.
// Misses fetch the whole row one word at a time; hits are combinational.
module edge_cache #(
   parameter int MAX_NODES   = 16,
   parameter int INDEX_WIDTH = 8,
   parameter int VALUE_WIDTH = 16,
   parameter int MADDR_WIDTH = 16,
   parameter int MDATA_WIDTH = 16
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [MADDR_WIDTH-1:0] base_address,
   input  logic [INDEX_WIDTH-1:0] number_of_nodes,
   input  logic                   query_enable,
   input  logic [INDEX_WIDTH-1:0] from_node,
   input  logic [INDEX_WIDTH-1:0] to_node,
   output wire  [MADDR_WIDTH-1:0] mem_addr,
   input  logic [MDATA_WIDTH-1:0] mem_data,
   output logic                   mem_read_enable,
   input  logic                   mem_read_ready,
   output logic                   ready,
   output logic [VALUE_WIDTH-1:0] edge_value
);

   localparam int CW = (MAX_NODES > 1) ? $clog2(MAX_NODES) : 1;
   localparam logic [MADDR_WIDTH-1:0] STRIDE =
      MADDR_WIDTH'(MADDR_WIDTH / 8);
   localparam logic [INDEX_WIDTH:0] MAXN =
      (INDEX_WIDTH + 1)'(MAX_NODES);
   localparam logic [INDEX_WIDTH-1:0] ONE = INDEX_WIDTH'(1);

   typedef enum logic [1:0] {
      IDLE,
      READ,
      GAP
   } state_t;

   state_t                 state;
   logic [MADDR_WIDTH-1:0] base_r;
   logic [MADDR_WIDTH-1:0] addr;
   logic [INDEX_WIDTH-1:0] n_r;
   logic [INDEX_WIDTH-1:0] line_row;
   logic [INDEX_WIDTH-1:0] col;
   logic                   line_valid;
   logic [VALUE_WIDTH-1:0] line_data [MAX_NODES];

   logic                   cfg_ok;
   logic                   in_range;
   logic                   hit;
   logic [MADDR_WIDTH-1:0] row_offset;

   // An unusable dimension disables fetching, so no line ever becomes valid
   assign cfg_ok   = (n_r != '0) && ({1'b0, n_r} <= MAXN);
   assign in_range = (from_node < n_r) && (to_node < n_r);
   assign hit      = line_valid && (from_node == line_row) && in_range;

   assign ready      = hit;
   assign edge_value = hit ? line_data[to_node[CW-1:0]] : '0;

   assign row_offset = MADDR_WIDTH'(from_node)
                     * MADDR_WIDTH'(n_r)
                     * STRIDE;

   assign mem_read_enable = (state == READ);
   assign mem_addr        = mem_read_enable ? addr : 'z;

   always_ff @(posedge clock) begin
      if (reset) begin
         base_r     <= base_address;
         n_r        <= number_of_nodes;
         line_valid <= 1'b0;
         line_row   <= '0;
         col        <= '0;
         addr       <= '0;
         state      <= IDLE;
      end else begin
         unique case (state)
            IDLE: begin
               if (query_enable && !hit && in_range && cfg_ok) begin
                  line_row   <= from_node;
                  line_valid <= 1'b0;
                  col        <= '0;
                  addr       <= base_r + row_offset;
                  state      <= READ;
               end
            end
            READ: begin
               if (mem_read_ready) begin
                  state <= GAP;
               end
            end
            GAP: begin
               if (col == n_r - ONE) begin
                  line_valid <= 1'b1;
                  state      <= IDLE;
               end else begin
                  col   <= col + ONE;
                  addr  <= addr + STRIDE;
                  state <= READ;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Line storage needs no reset: line_valid gates every use of it
   always_ff @(posedge clock) begin
      if (!reset && state == READ && mem_read_ready) begin
         line_data[col[CW-1:0]] <= mem_data[VALUE_WIDTH-1:0];
      end
   end

endmodule

// File: tb/tb_edge_cache.sv
// Bench for edge_cache: vector table, hand sequences, random queries
// checked against a row-cache model over a behavioural RAM.
module tb_edge_cache;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] base_address = 16'd64;
   logic [7:0]  number_of_nodes = 8'd4;
   logic        query_enable = 1'b0;
   logic [7:0]  from_node = '0;
   logic [7:0]  to_node = '0;
   wire  [15:0] mem_addr;
   logic [15:0] mem_data = '0;
   logic        mem_read_enable;
   logic        mem_read_ready = 1'b0;
   logic        ready;
   logic [15:0] edge_value;

   edge_cache dut (
      .clock          (clock),
      .reset          (reset),
      .base_address   (base_address),
      .number_of_nodes(number_of_nodes),
      .query_enable   (query_enable),
      .from_node      (from_node),
      .to_node        (to_node),
      .mem_addr       (mem_addr),
      .mem_data       (mem_data),
      .mem_read_enable(mem_read_enable),
      .mem_read_ready (mem_read_ready),
      .ready          (ready),
      .edge_value     (edge_value)
   );

   always #5 clock = ~clock;

   logic [15:0] ram [0:65535];
   int          ram_lat = 0;
   int          lat_cnt = 0;

   // RAM answers each request after ram_lat extra cycles, one-cycle strobe
   always @(posedge clock) begin
      if (mem_read_enable && !mem_read_ready) begin
         if (lat_cnt >= ram_lat) begin
            mem_read_ready <= 1'b1;
            mem_data       <= ram[mem_addr];
            lat_cnt        <= 0;
         end else begin
            lat_cnt <= lat_cnt + 1;
         end
      end else begin
         mem_read_ready <= 1'b0;
         lat_cnt        <= 0;
      end
   end

   int n_vec = 0;
   int n_bad = 0;
   int addrs[$];

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic do_reset(input logic [15:0] b, input logic [7:0] n);
      @(negedge clock);
      reset = 1'b1;
      base_address = b;
      number_of_nodes = n;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      base_address = 16'd87;
      number_of_nodes = 8'd105;
   endtask

   task automatic run_query(input logic [7:0] f,
                            input logic [7:0] t,
                            input int budget,
                            output logic rdy,
                            output logic [15:0] val,
                            output int nreads);
      logic prev;
      from_node = f;
      to_node = t;
      query_enable = 1'b1;
      rdy = 1'b0;
      val = '0;
      nreads = 0;
      prev = 1'b0;
      addrs.delete();
      for (int i = 0; i < budget; i++) begin
         #1;
         if (ready) begin
            rdy = 1'b1;
            val = edge_value;
            break;
         end
         @(negedge clock);
         if (mem_read_enable && !prev) begin
            nreads++;
            addrs.push_back(int'(mem_addr));
         end
         prev = mem_read_enable;
      end
   endtask

   typedef struct {
      logic [7:0]  f;
      logic [7:0]  t;
      logic        rdy;
      logic [15:0] val;
      int          reads;
   } vec_t;

   vec_t        tbl[18];
   logic        rdy;
   logic [15:0] val;
   int          nr;
   int          cnt;
   logic        prev;

   initial begin
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            tbl[r*4+c] = '{8'(r), 8'(c), 1'b1,
                           16'(r*c), (c == 0) ? 4 : 0};
      tbl[16] = '{8'd1, 8'd4, 1'b0, 16'd0, 0};
      tbl[17] = '{8'd1, 8'd1, 1'b1, 16'd1, 4};

      for (int i = 0; i < 65536; i++) ram[i] = 16'($urandom);
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            ram[64 + (r*4+c)*2] = 16'(r*c);

      // Reset state
      repeat (2) @(negedge clock);
      chk("rst_ready", 32'(ready), 0);
      chk("rst_value", 32'(edge_value), 0);
      chk("rst_ren", 32'(mem_read_enable), 0);
      reset = 1'b0;
      base_address = 16'd87;
      number_of_nodes = 8'd105;

      // Table sweep
      foreach (tbl[i]) begin
         run_query(tbl[i].f, tbl[i].t, tbl[i].rdy ? 200 : 20,
                   rdy, val, nr);
         chk($sformatf("tbl%0d_ready", i), 32'(rdy), 32'(tbl[i].rdy));
         chk($sformatf("tbl%0d_value", i), 32'(val), 32'(tbl[i].val));
         chk($sformatf("tbl%0d_reads", i), nr, tbl[i].reads);
         if (tbl[i].reads == 4)
            for (int k = 0; k < 4 && k < addrs.size(); k++)
               chk($sformatf("tbl%0d_addr%0d", i, k), addrs[k],
                   64 + int'(tbl[i].f)*8 + k*2);
      end

      // Combinational hit tracking on row 2, then row switch
      run_query(8'd2, 8'd0, 200, rdy, val, nr);
      chk("row2_value0", 32'(val), 0);
      to_node = 8'd3;
      #1;
      chk("comb_ready", 32'(ready), 1);
      chk("comb_value", 32'(edge_value), 6);
      from_node = 8'd3;
      #1;
      chk("switch_drop", 32'(ready), 0);
      run_query(8'd3, 8'd3, 200, rdy, val, nr);
      chk("row3_ready", 32'(rdy), 1);
      chk("row3_value", 32'(val), 9);
      chk("row3_reads", nr, 4);

      // Reset during the third read of a row fill
      ram_lat = 2;
      from_node = 8'd2;
      to_node = 8'd3;
      cnt = 0;
      prev = 1'b0;
      for (int i = 0; i < 200 && cnt < 3; i++) begin
         @(negedge clock);
         if (mem_read_enable && !prev) cnt++;
         prev = mem_read_enable;
      end
      chk("midfill_reached", cnt, 3);
      reset = 1'b1;
      base_address = 16'd64;
      number_of_nodes = 8'd4;
      @(negedge clock);
      chk("abort_ren", 32'(mem_read_enable), 0);
      chk("abort_ready", 32'(ready), 0);
      reset = 1'b0;
      run_query(8'd2, 8'd3, 200, rdy, val, nr);
      chk("refetch_ready", 32'(rdy), 1);
      chk("refetch_value", 32'(val), 6);
      chk("refetch_reads", nr, 4);

      // query_enable low with no valid line
      do_reset(16'd64, 8'd4);
      query_enable = 1'b0;
      from_node = 8'd1;
      to_node = 8'd1;
      cnt = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clock);
         if (mem_read_enable || ready) cnt++;
      end
      chk("noquery_idle", cnt, 0);
      run_query(8'd1, 8'd1, 200, rdy, val, nr);
      chk("noquery_then_ready", 32'(rdy), 1);
      chk("noquery_then_value", 32'(val), 1);

      // Unsupported dimensions never fetch
      do_reset(16'd64, 8'd20);
      run_query(8'd1, 8'd1, 30, rdy, val, nr);
      chk("n20_ready", 32'(rdy), 0);
      chk("n20_reads", nr, 0);
      do_reset(16'd64, 8'd0);
      run_query(8'd0, 8'd0, 30, rdy, val, nr);
      chk("n0_ready", 32'(rdy), 0);
      chk("n0_reads", nr, 0);

      // Random configs and queries against a single-row cache model
      for (int cfg = 0; cfg < 6; cfg++) begin
         int          n;
         logic [15:0] b;
         int          m_row;
         logic        m_valid;
         n = $urandom_range(1, 16);
         b = 16'($urandom);
         m_valid = 1'b0;
         m_row = 0;
         do_reset(b, 8'(n));
         for (int q = 0; q < 12; q++) begin
            int          f;
            int          t;
            logic        inr;
            logic        hit;
            logic [15:0] ev;
            f = $urandom_range(0, n);
            t = $urandom_range(0, n);
            ram_lat = $urandom_range(0, 3);
            inr = (f < n) && (t < n);
            hit = inr && m_valid && (f == m_row);
            ev = inr ? ram[16'(int'(b) + (f*n + t)*2)] : 16'd0;
            run_query(8'(f), 8'(t), inr ? 200 : 15, rdy, val, nr);
            chk($sformatf("rnd%0d_%0d_ready", cfg, q),
                32'(rdy), 32'(inr));
            chk($sformatf("rnd%0d_%0d_value", cfg, q),
                32'(val), 32'(ev));
            chk($sformatf("rnd%0d_%0d_reads", cfg, q),
                nr, (inr && !hit) ? n : 0);
            if (inr) begin
               m_valid = 1'b1;
               m_row = f;
            end
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_bad);
      $finish;
   end

endmodule
